even_issue_ctrl: RTL and testbench

- In-order issue controller for the even-pipe execution units (simple fixed, byte, single-precision, double-precision) that share one register-file writeback port.
- Tracks in-flight destination registers in a 128-entry countdown scoreboard and a writeback-slot reservation vector.
- Stalls decode on read-after-write (RAW) hazards, write-after-write (WAW) hazards and writeback-port collisions.
- Forwards each accepted instruction to the selected unit with a one-cycle registered issue.

---
 rtl/even_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_even_issue_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_issue_ctrl.sv
// even_issue_ctrl: in-order issue control for the even-pipe units.
// Countdown scoreboard plus writeback-slot reservation on one WB port.
module even_issue_ctrl #(
    parameter int unsigned LAT0 = 2,
    parameter int unsigned LAT1 = 4,
    parameter int unsigned LAT2 = 6,
    parameter int unsigned LAT3 = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_unit,
    input  logic [6:0]  in_rt_addr,
    input  logic        in_reg_write,
    input  logic [6:0]  in_ra_addr,
    input  logic [6:0]  in_rb_addr,
    input  logic [6:0]  in_rc_addr,
    input  logic        in_ra_use,
    input  logic        in_rb_use,
    input  logic        in_rc_use,
    output logic        issue_valid,
    output logic [1:0]  issue_unit,
    output logic [6:0]  issue_rt_addr,
    output logic        issue_reg_write,
    output logic        busy,
    output logic [31:0] stall_count
);

    // Every latency must lie in 1..7 so it fits the 3-bit countdown.
    localparam logic [2:0] L0 = 3'(LAT0);
    localparam logic [2:0] L1 = 3'(LAT1);
    localparam logic [2:0] L2 = 3'(LAT2);
    localparam logic [2:0] L3 = 3'(LAT3);

    logic [2:0]  pend_q [128];
    logic [2:0]  pend_d [128];
    logic [7:1]  wbv_q;
    logic [7:1]  wbv_d;

    logic        issue_valid_q;
    logic        issue_valid_d;
    logic [1:0]  issue_unit_q;
    logic [1:0]  issue_unit_d;
    logic [6:0]  issue_rt_addr_q;
    logic [6:0]  issue_rt_addr_d;
    logic        issue_reg_write_q;
    logic        issue_reg_write_d;
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    logic [2:0]  lat;
    logic        raw;
    logic        waw;
    logic        wb_hit;
    logic        accept;
    logic        wr_accept;

    // Writeback latency of the unit targeted by the decoded instruction.
    always_comb begin
        lat = L0;
        unique case (in_unit)
            2'd0: lat = L0;
            2'd1: lat = L1;
            2'd2: lat = L2;
            2'd3: lat = L3;
        endcase
    end

    // Hazard detection on current state; in_valid deliberately not used.
    always_comb begin
        raw = (in_ra_use && (pend_q[in_ra_addr] != 3'd0))
           || (in_rb_use && (pend_q[in_rb_addr] != 3'd0))
           || (in_rc_use && (pend_q[in_rc_addr] != 3'd0));
        waw = in_reg_write && (pend_q[in_rt_addr] != 3'd0);
        wb_hit = in_reg_write && wbv_q[lat];
    end

    assign in_ready  = !(raw || waw || wb_hit);
    assign accept    = in_valid && in_ready;
    assign wr_accept = accept && in_reg_write;

    // Scoreboard countdown; an accepted writer reloads its entry.
    always_comb begin
        for (int i = 0; i < 128; i++) begin
            if (pend_q[i] != 3'd0) begin
                pend_d[i] = pend_q[i] - 3'd1;
            end else begin
                pend_d[i] = 3'd0;
            end
        end
        if (wr_accept) begin
            pend_d[in_rt_addr] = lat - 3'd1;
        end
    end

    // Slot vector: bit k means a writeback k cycles from now. The new
    // writer lands at L cycles from this cycle, i.e. L-1 from the next
    // one, so it is recorded after the shift. An L=1 writer lands in
    // the very next cycle, which no later accept can target.
    always_comb begin
        wbv_d = {1'b0, wbv_q[7:2]};
        if (wr_accept && (lat != 3'd1)) begin
            wbv_d[lat - 3'd1] = 1'b1;
        end
    end

    // Issue register captures the accepted instruction, else holds.
    always_comb begin
        issue_valid_d     = accept;
        issue_unit_d      = issue_unit_q;
        issue_rt_addr_d   = issue_rt_addr_q;
        issue_reg_write_d = issue_reg_write_q;
        if (accept) begin
            issue_unit_d      = in_unit;
            issue_rt_addr_d   = in_rt_addr;
            issue_reg_write_d = in_reg_write;
        end
    end

    // Saturating count of cycles a valid instruction was held back.
    always_comb begin
        stall_count_d = stall_count_q;
        if (in_valid && !in_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Busy while any destination is still counting down.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < 128; i++) begin
            busy = busy | (pend_q[i] != 3'd0);
        end
    end

    // State update; reset drops all in-flight tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                pend_q[i] <= 3'd0;
            end
            wbv_q             <= '0;
            issue_valid_q     <= 1'b0;
            issue_unit_q      <= 2'd0;
            issue_rt_addr_q   <= 7'd0;
            issue_reg_write_q <= 1'b0;
            stall_count_q     <= 32'd0;
        end else begin
            for (int i = 0; i < 128; i++) begin
                pend_q[i] <= pend_d[i];
            end
            wbv_q             <= wbv_d;
            issue_valid_q     <= issue_valid_d;
            issue_unit_q      <= issue_unit_d;
            issue_rt_addr_q   <= issue_rt_addr_d;
            issue_reg_write_q <= issue_reg_write_d;
            stall_count_q     <= stall_count_d;
        end
    end

    assign issue_valid     = issue_valid_q;
    assign issue_unit      = issue_unit_q;
    assign issue_rt_addr   = issue_rt_addr_q;
    assign issue_reg_write = issue_reg_write_q;
    assign stall_count     = stall_count_q;

endmodule

// File: tb/tb_even_issue_ctrl.sv
// tb_even_issue_ctrl: directed and randomized checks of even_issue_ctrl.
// Reference model tracks absolute writeback cycles per register/slot.
module tb_even_issue_ctrl;

    localparam int LT0 = 2;
    localparam int LT1 = 4;
    localparam int LT2 = 6;
    localparam int LT3 = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_unit;
    logic [6:0]  in_rt_addr;
    logic        in_reg_write;
    logic [6:0]  in_ra_addr;
    logic [6:0]  in_rb_addr;
    logic [6:0]  in_rc_addr;
    logic        in_ra_use;
    logic        in_rb_use;
    logic        in_rc_use;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [6:0]  issue_rt_addr;
    logic        issue_reg_write;
    logic        busy;
    logic [31:0] stall_count;

    int total = 0;
    int bad = 0;

    // reference model state
    int          cyc = 0;
    int          wb_at [128];
    bit          slot_used [0:8191];
    int unsigned m_stall = 0;
    bit          m_iv = 0;
    logic [1:0]  m_iu = 0;
    logic [6:0]  m_irt = 0;
    bit          m_irw = 0;

    always #5 clk = ~clk;

    even_issue_ctrl #(
        .LAT0(LT0),
        .LAT1(LT1),
        .LAT2(LT2),
        .LAT3(LT3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_unit(in_unit),
        .in_rt_addr(in_rt_addr),
        .in_reg_write(in_reg_write),
        .in_ra_addr(in_ra_addr),
        .in_rb_addr(in_rb_addr),
        .in_rc_addr(in_rc_addr),
        .in_ra_use(in_ra_use),
        .in_rb_use(in_rb_use),
        .in_rc_use(in_rc_use),
        .issue_valid(issue_valid),
        .issue_unit(issue_unit),
        .issue_rt_addr(issue_rt_addr),
        .issue_reg_write(issue_reg_write),
        .busy(busy),
        .stall_count(stall_count)
    );

    function automatic int lat_of(input logic [1:0] u);
        case (u)
            2'd0: return LT0;
            2'd1: return LT1;
            2'd2: return LT2;
            default: return LT3;
        endcase
    endfunction

    // A register is unreadable until the cycle its writeback lands.
    function automatic bit m_ready();
        int l;
        bit raw, waw, wbc;
        l = lat_of(in_unit);
        raw = (in_ra_use && cyc < wb_at[in_ra_addr])
           || (in_rb_use && cyc < wb_at[in_rb_addr])
           || (in_rc_use && cyc < wb_at[in_rc_addr]);
        waw = in_reg_write && cyc < wb_at[in_rt_addr];
        wbc = in_reg_write && slot_used[cyc + l];
        return !(raw || waw || wbc);
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < 128; r++)
            if (cyc < wb_at[r]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance model and DUT across one clock edge.
    task automatic tick();
        bit rdy;
        int l;
        rdy = m_ready();
        l = lat_of(in_unit);
        if (reset) begin
            for (int r = 0; r < 128; r++) wb_at[r] = 0;
            for (int s = 0; s < 8192; s++) slot_used[s] = 1'b0;
            m_stall = 0;
            m_iv = 0;
            m_iu = 0;
            m_irt = 0;
            m_irw = 0;
        end else begin
            if (in_valid && !rdy && m_stall != 32'hFFFF_FFFF)
                m_stall++;
            m_iv = in_valid && rdy;
            if (m_iv) begin
                m_iu = in_unit;
                m_irt = in_rt_addr;
                m_irw = in_reg_write;
                if (in_reg_write) begin
                    wb_at[in_rt_addr] = cyc + l;
                    slot_used[cyc + l] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit v, input int u, input int rt,
                         input bit rw, input int ra, input bit rau,
                         input int rb, input bit rbu,
                         input int rc, input bit rcu);
        in_valid = v;
        in_unit = 2'(u);
        in_rt_addr = 7'(rt);
        in_reg_write = rw;
        in_ra_addr = 7'(ra);
        in_ra_use = rau;
        in_rb_addr = 7'(rb);
        in_rb_use = rbu;
        in_rc_addr = 7'(rc);
        in_rc_use = rcu;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%0b want=1", in_ready);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%0b want=0", busy);
        end
        total++;
        if (issue_valid !== 1'b0 || issue_unit !== 2'd0 ||
            issue_rt_addr !== 7'd0 || issue_reg_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_issue got=%0b/%0d/%0d/%0b want=0/0/0/0",
                     issue_valid, issue_unit, issue_rt_addr, issue_reg_write);
        end
        total++;
        if (stall_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_stall got=%0d want=0", stall_count);
        end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        drive(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL raw_prod got=%0b want=1", in_ready);
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(1, 0, 6, 0, 5, 1, 0, 0, 0, 0);
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL raw_stall_c%0d got=%0b want=0", c, in_ready);
            end
            if (c == 1) begin
                total++;
                if (issue_valid !== 1'b1 || issue_unit !== 2'd1 ||
                    issue_rt_addr !== 7'd5 || issue_reg_write !== 1'b1) begin
                    bad++;
                    $display("FAIL raw_issue got=%0b/%0d/%0d/%0b want=1/1/5/1",
                             issue_valid, issue_unit, issue_rt_addr,
                             issue_reg_write);
                end
            end
            tick();
        end
        drive(1, 0, 6, 0, 5, 1, 0, 0, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL raw_accept_c4 got=%0b want=1", in_ready);
        end
        tick();
        idle();
        #1;
        total++;
        if (stall_count !== 32'd3) begin
            bad++;
            $display("FAIL raw_stall_count got=%0d want=3", stall_count);
        end
        total++;
        if (issue_valid !== 1'b1 || issue_rt_addr !== 7'd6) begin
            bad++;
            $display("FAIL raw_dep_issue got=%0b/%0d want=1/6",
                     issue_valid, issue_rt_addr);
        end
        tick();
    endtask

    task automatic test_wb_collision();
        do_reset();
        drive(1, 3, 10, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        tick();
        drive(1, 1, 11, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL wb_stall_c3 got=%0b want=0", in_ready);
        end
        tick();
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL wb_accept_c4 got=%0b want=1", in_ready);
        end
        tick();
        idle();
        tick();
        tick();
        drive(1, 0, 12, 0, 0, 0, 11, 1, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wb_c7 got ready=%0b busy=%0b want 0/1",
                     in_ready, busy);
        end
        tick();
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wb_c8 got ready=%0b busy=%0b want 1/0",
                     in_ready, busy);
        end
        tick();
        idle();
    endtask

    task automatic test_waw();
        do_reset();
        drive(1, 2, 20, 1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            drive(1, 0, 20, 1, 0, 0, 0, 0, 0, 0);
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL waw_stall_c%0d got=%0b want=0", c, in_ready);
            end
            tick();
        end
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL waw_accept_c6 got=%0b want=1", in_ready);
        end
        tick();
        idle();
        #1;
        total++;
        if (stall_count !== 32'd5) begin
            bad++;
            $display("FAIL waw_stall_count got=%0d want=5", stall_count);
        end
        tick();
    endtask

    task automatic test_nop();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 3, c + 1, 1, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL nop_accept got ready=%0b busy=%0b want 1/1",
                     in_ready, busy);
        end
        tick();
        drive(1, 1, 40, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (issue_valid !== 1'b1 || issue_reg_write !== 1'b0 ||
            issue_unit !== 2'd2) begin
            bad++;
            $display("FAIL nop_issue got=%0b/%0b/%0d want=1/0/2",
                     issue_valid, issue_reg_write, issue_unit);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL nop_slot_kept got=%0b want=0", in_ready);
        end
        drive(1, 0, 40, 1, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL nop_free_slot got=%0b want=1", in_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 3, 30, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 2, 31, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 32, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        total++;
        if (busy !== 1'b0 || issue_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got busy=%0b iv=%0b want 0/0",
                     busy, issue_valid);
        end
        drive(1, 3, 32, 1, 30, 1, 31, 1, 32, 1);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_dep got=%0b want=1", in_ready);
        end
        tick();
        idle();
        #1;
        total++;
        if (issue_valid !== 1'b1 || issue_rt_addr !== 7'd32) begin
            bad++;
            $display("FAIL mid_reset_issue got=%0b/%0d want=1/32",
                     issue_valid, issue_rt_addr);
        end
        tick();
    endtask

    task automatic test_random();
        bit wide;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            wide = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3),
                  wide ? $urandom_range(0, 127) : $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 3) == 0,
                  wide ? $urandom_range(0, 127) : $urandom_range(0, 7),
                  $urandom_range(0, 4) == 0);
            #1;
            total++;
            if (in_ready !== m_ready()) begin
                bad++;
                $display("FAIL rnd_ready n=%0d got=%0b want=%0b",
                         n, in_ready, m_ready());
            end
            total++;
            if (busy !== m_busy()) begin
                bad++;
                $display("FAIL rnd_busy n=%0d got=%0b want=%0b",
                         n, busy, m_busy());
            end
            total++;
            if (issue_valid !== m_iv || issue_unit !== m_iu ||
                issue_rt_addr !== m_irt || issue_reg_write !== m_irw) begin
                bad++;
                $display("FAIL rnd_issue n=%0d got=%0b/%0d/%0d/%0b want=%0b/%0d/%0d/%0b",
                         n, issue_valid, issue_unit, issue_rt_addr,
                         issue_reg_write, m_iv, m_iu, m_irt, m_irw);
            end
            total++;
            if (stall_count !== m_stall) begin
                bad++;
                $display("FAIL rnd_stall n=%0d got=%0d want=%0d",
                         n, stall_count, m_stall);
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        for (int r = 0; r < 128; r++) wb_at[r] = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_wb_collision();
        test_waw();
        test_nop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
